// File: rtl/stream_distributor.sv
// Fan-out of one valid/ready stream onto NS sinks, each with a one-deep holding slot.
// Sink choice is round-robin among slots that are empty or being drained this cycle.
module stream_distributor #(
    parameter int unsigned NS = 2,
    parameter int unsigned DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DW-1:0]         in_dat,
    output logic [NS-1:0]         out_vld,
    input  logic [NS-1:0]         out_rdy,
    output logic [NS-1:0][DW-1:0] out_dat,
    output logic [$clog2(NS)-1:0] out_sel
);

    localparam int unsigned SW = $clog2(NS);

    logic [NS-1:0]         full;
    logic [NS-1:0][DW-1:0] dat;
    logic [SW-1:0]         rr;
    logic [SW-1:0]         sel;

    logic [NS-1:0]         avail;
    logic                  any_avail;
    logic                  found;
    logic [SW-1:0]         tgt;
    logic [SW-1:0]         rr_nxt;
    logic                  take;
    int unsigned           scan_idx;

    // Rotating priority scan starting at rr; a full slot being drained counts as free.
    always_comb begin
        avail     = ~full | out_rdy;
        any_avail = |avail;
        found     = 1'b0;
        tgt       = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NS; i++) begin
            scan_idx = (32'(rr) + i) % NS;
            if (!found && avail[scan_idx]) begin
                found = 1'b1;
                tgt   = SW'(scan_idx);
            end
        end
    end

    assign rr_nxt = (tgt == SW'(NS - 1)) ? '0 : tgt + SW'(1);
    assign in_rdy = clk_en & any_avail;
    assign take   = in_vld & in_rdy;

    // Slot state: a reload wins over a drain, so drain+reload keeps the slot full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            dat  <= '0;
            rr   <= '0;
            sel  <= '0;
        end else if (clk_en) begin
            for (int unsigned s = 0; s < NS; s++) begin
                if (take && (tgt == SW'(s))) begin
                    full[s] <= 1'b1;
                    dat[s]  <= in_dat;
                end else if (full[s] && out_rdy[s]) begin
                    full[s] <= 1'b0;
                end
            end
            if (take) begin
                sel <= tgt;
                rr  <= rr_nxt;
            end
        end
    end

    assign out_vld = full;
    assign out_dat = dat;
    assign out_sel = sel;

endmodule

// File: tb/tb_stream_distributor.sv
// Bench for stream_distributor (NS=4, DW=8): directed scenarios plus a random soak,
// checked every cycle against a queue-based model of the slots.
module tb_stream_distributor;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic                  clk;
    logic                  rst;
    logic                  clk_en;
    logic                  in_vld;
    logic                  in_rdy;
    logic [DW-1:0]         in_dat;
    logic [NS-1:0]         out_vld;
    logic [NS-1:0]         out_rdy;
    logic [NS-1:0][DW-1:0] out_dat;
    logic [SW-1:0]         out_sel;

    int errors = 0;
    int checks = 0;

    // Model: per-slot occupancy/data, rotating start point, per-sink queues of owed words
    bit            m_full[NS];
    logic [DW-1:0] m_dat[NS];
    int            m_rr = 0;
    int            m_sel = 0;
    logic [DW-1:0] exp_q[NS][$];
    int            accepted = 0;
    int            drained = 0;
    int            drain_cnt[NS];

    stream_distributor #(.NS(NS), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_dat  (in_dat),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .out_sel (out_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First slot, from m_rr onwards with wrap, that is empty or has its sink ready
    function automatic int m_target();
        for (int i = 0; i < NS; i++) begin
            int s;
            s = (m_rr + i) % NS;
            if (!m_full[s] || out_rdy[s]) return s;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int t;
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                m_full[s] = 1'b0;
                m_dat[s]  = '0;
                exp_q[s].delete();
            end
            m_rr  = 0;
            m_sel = 0;
        end else if (clk_en) begin
            t = m_target();
            for (int s = 0; s < NS; s++)
                if (m_full[s] && out_rdy[s]) m_full[s] = 1'b0;
            if (in_vld && t >= 0) begin
                m_full[t] = 1'b1;
                m_dat[t]  = in_dat;
                exp_q[t].push_back(in_dat);
                m_sel = t;
                m_rr  = (t + 1) % NS;
                accepted++;
            end
        end
    end

    always @(negedge clk) begin : compare
        int t;
        t = m_target();
        chk("in_rdy", in_rdy, clk_en && (t >= 0));
        chk("out_sel", out_sel, m_sel);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("out_vld[%0d]", s), out_vld[s], m_full[s]);
            chk($sformatf("out_dat[%0d]", s), out_dat[s], m_dat[s]);
            if (!rst && clk_en && out_vld[s] && out_rdy[s]) begin
                if (exp_q[s].size() == 0)
                    chk($sformatf("spurious_out[%0d]", s), 1, 0);
                else
                    chk($sformatf("order[%0d]", s), out_dat[s], exp_q[s].pop_front());
                drained++;
                drain_cnt[s]++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_vld = 1'b1;
        in_dat = d;
        cycle();
        in_vld = 1'b0;
    endtask

    initial begin : stim
        int base_acc;
        int base_drn;
        int base_cnt[NS];
        int cyc;
        logic [7:0] fill_words[4];
        fill_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int s = 0; s < NS; s++) begin
            m_full[s]    = 1'b0;
            m_dat[s]     = '0;
            drain_cnt[s] = 0;
        end

        rst = 1'b1; clk_en = 1'b1; in_vld = 1'b0; in_dat = '0; out_rdy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_vld", out_vld, 4'b0000);
        chk("rst in_rdy", in_rdy, 1'b1);
        chk("rst out_sel", out_sel, 2'd0);
        chk("rst out_dat", out_dat, 32'h0);
        cycle();
        rst = 1'b0;

        // Round-robin fill, then a stalled fifth word
        in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_dat = fill_words[i];
            cycle();
        end
        in_dat = 8'h55;
        @(negedge clk);
        chk("fill out_vld", out_vld, 4'b1111);
        chk("fill in_rdy", in_rdy, 1'b0);
        chk("fill out_dat", out_dat, 32'h44332211);
        cycle();
        out_rdy = 4'b0100;
        @(negedge clk);
        chk("passthru in_rdy", in_rdy, 1'b1);
        cycle();
        in_vld = 1'b0; out_rdy = '0;
        @(negedge clk);
        chk("passthru out_vld", out_vld, 4'b1111);
        chk("passthru out_dat2", out_dat[2], 8'h55);
        chk("passthru out_sel", out_sel, 2'd2);

        // Build rr=1 with slots 1,2 busy and 0,3 empty
        out_rdy = 4'b1111; cycle(); out_rdy = '0;
        send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
        out_rdy = 4'b0001; send(8'hB4);
        out_rdy = 4'b1001; cycle(); out_rdy = '0;
        send(8'hA0);
        @(negedge clk);
        chk("skip out_sel A0", out_sel, 2'd3);
        chk("skip out_dat3", out_dat[3], 8'hA0);
        cycle();
        send(8'hA1);
        @(negedge clk);
        chk("wrap out_sel A1", out_sel, 2'd0);
        chk("wrap out_dat", out_dat, 32'hA0B3B2A1);
        chk("wrap out_vld", out_vld, 4'b1111);

        // Clock-enable gating with everything requesting
        cycle();
        clk_en = 1'b0; in_vld = 1'b1; in_dat = 8'hC0; out_rdy = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gate in_rdy", in_rdy, 1'b0);
            chk("gate out_vld", out_vld, 4'b1111);
            chk("gate out_dat", out_dat, 32'hA0B3B2A1);
            cycle();
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("ungate in_rdy", in_rdy, 1'b1);
        cycle();
        in_vld = 1'b0; out_rdy = '0;
        @(negedge clk);
        chk("ungate out_sel", out_sel, 2'd1);
        chk("ungate out_vld", out_vld, 4'b0010);
        chk("ungate out_dat1", out_dat[1], 8'hC0);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async rst out_vld", out_vld, 4'b0000);
        chk("async rst out_dat", out_dat, 32'h0);
        cycle();
        rst = 1'b0;

        // Random soak
        base_acc = accepted;
        base_drn = drained;
        for (int s = 0; s < NS; s++) base_cnt[s] = drain_cnt[s];
        cyc = 0;
        while ((accepted - base_acc) < 1000 && cyc < 20000) begin
            clk_en  = ($urandom_range(0, 9) != 0);
            in_vld  = ($urandom_range(0, 9) < 7);
            in_dat  = 8'($urandom);
            out_rdy = 4'($urandom);
            cycle();
            cyc++;
        end
        chk("soak word budget reached", ((accepted - base_acc) >= 1000), 1'b1);
        clk_en = 1'b1; in_vld = 1'b0; out_rdy = 4'b1111;
        cycle(); cycle();
        @(negedge clk);
        chk("soak drained all", out_vld, 4'b0000);
        chk("soak in==out count", drained - base_drn, accepted - base_acc);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("soak leftover[%0d]", s), exp_q[s].size(), 0);
            chk($sformatf("soak served[%0d]", s), (drain_cnt[s] - base_cnt[s]) > 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_distributor.md
Name: stream_distributor

Overview:
- Fan-out counterpart to the priority-encoded stream collector: one input valid/ready stream is dispatched to NS output streams.
- Typical use: hand pixel jobs from a single coordinate generator to NS parallel iteration engines, whose results are later merged by the collector.
- Each output has its own one-deep holding register, so one stalled engine does not block the others.
- Output selection is round-robin among the outputs that can accept a word, for fairness.

Parameters:
- NS, 2, number of output sinks (NS >= 2).
- DW, 32, data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- clk_en  input  1  clock enable; no state changes and no handshakes complete while low.
- in_vld  input  1  input valid.
- in_rdy  output  1  input ready.
- in_dat  input  DW  input data.
- out_vld  output  NS  per-sink valid.
- out_rdy  input  NS  per-sink ready.
- out_dat  output  [NS-1:0][DW-1:0]  per-sink data (packed array).
- out_sel  output  $clog2(NS)  index of the sink that received the most recent accepted input word.

Behaviour:
- Reset (asynchronous, active-high, applied immediately): all slot full flags = 0, so out_vld = 0. All out_dat = 0. Round-robin pointer rr = 0. out_sel = 0.
- Slot s is available when ~full[s] || out_rdy[s]. This gives same-cycle pass-through: a full slot being drained this cycle can accept a new word in the same cycle.
- Target selection (combinational): tgt = first available slot scanning rr, rr+1, … NS-1, 0, … rr-1, wrapping modulo NS.
- any_avail = OR of all available flags.
- in_rdy = clk_en && any_avail.
- An input transfer occurs when in_vld && in_rdy. On the next rising edge:
  - slot tgt: out_dat[tgt] <= in_dat and full[tgt] <= 1;
  - out_sel <= tgt;
  - rr <= (tgt == NS-1) ? 0 : tgt+1.
- Output transfer on sink s occurs when clk_en && out_vld[s] && out_rdy[s]. If slot s is not reloaded in that cycle, full[s] <= 0.
- If slot s is drained and reloaded in the same cycle, full[s] stays 1 and out_dat[s] takes the new word.
- out_vld[s] = full[s], registered. Latency from input transfer to out_vld is exactly 1 cycle.
- Each input word goes to exactly one sink. No word is duplicated or dropped.
- Data ordering is preserved per sink, not across sinks.
- Stability: out_dat[s] and out_vld[s] hold stable while out_vld[s]=1 && out_rdy[s]=0.
- in_vld is not gated into state: with in_vld=0, rr and the slots change only through drains.
- clk_en=0: all registers hold; in_rdy = 0; out_vld/out_dat hold. An out_rdy pulse while clk_en=0 does not drain the slot.
- All slots full and no out_rdy: in_rdy = 0 and rr holds.
- Wrap-around: with rr = NS-1 and slot NS-1 unavailable, selection continues at slot 0.
- Reset mid-operation: buffered words are discarded, with no partial output.
- Implementation: rotate-priority scan, either a doubled-vector priority encoder or a loop. No latches; fully synchronous apart from the reset.

Test Plan (NS=4, DW=8):
- Reset: hold rst high and pulse clk -> out_vld=4'b0000, in_rdy=1 (clk_en=1), out_sel=0. Assert rst asynchronously mid-cycle with slots full -> out_vld drops to 0 without waiting for a clock edge.
- Round-robin fill: all out_rdy=0; present 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> out_dat[0..3] = 11, 22, 33, 44 and out_vld=1111. Then in_rdy=0 and a 5th word 0x55 is stalled.
- Pass-through drain: from the full state, raise out_rdy[2] only while 0x55 is pending -> in the same cycle 0x55 goes to slot 2, out_vld stays 1111, out_sel=2, next target scan starts at 3.
- Skip busy sinks: rr=1, slots 1 and 2 full with out_rdy=0, slots 0 and 3 empty; send 0xA0 then 0xA1 -> 0xA0 goes to slot 3, 0xA1 goes to slot 0.
- clk_en gating: clk_en=0 with in_vld=1 and all out_rdy=1 for 3 cycles -> in_rdy=0 and no register changes. Re-enable clk_en -> transfers resume at the same rr.
- Random soak: 1000 words with random in_vld and per-sink random out_rdy; the scoreboard checks:
  - the multiset of all sink outputs equals the input set;
  - per-sink order is preserved;
  - no sink is starved while it keeps out_rdy=1.
